cache_arb: RTL and testbench

CACHE_ARB -- requirements
Module: cache_arb

---
 rtl/cache_arb.sv | 137 +++++++++++++
 tb/tb_cache_arb.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arb.sv
// Two-master Wishbone arbiter in front of a shared cache slave port, with per-master grant counters.
// Define CACHE_ARB_RR_EN for round-robin tie-breaking from IDLE; otherwise master 0 wins ties.
module cache_arb #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                m0_cyc_i,
   input  logic                m0_stb_i,
   input  logic                m0_we_i,
   input  logic [AWIDTH-1:0]   m0_adr_i,
   input  logic [DWIDTH-1:0]   m0_dat_i,
   input  logic [DWIDTH/8-1:0] m0_sel_i,
   output logic [DWIDTH-1:0]   m0_dat_o,
   output logic                m0_ack_o,
   output logic                m0_stall_o,
   input  logic                m1_cyc_i,
   input  logic                m1_stb_i,
   input  logic                m1_we_i,
   input  logic [AWIDTH-1:0]   m1_adr_i,
   input  logic [DWIDTH-1:0]   m1_dat_i,
   input  logic [DWIDTH/8-1:0] m1_sel_i,
   output logic [DWIDTH-1:0]   m1_dat_o,
   output logic                m1_ack_o,
   output logic                m1_stall_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_we_o,
   output logic [AWIDTH-1:0]   s_adr_o,
   output logic [DWIDTH-1:0]   s_dat_o,
   output logic [DWIDTH/8-1:0] s_sel_o,
   input  logic [DWIDTH-1:0]   s_dat_i,
   input  logic                s_ack_i,
   input  logic                s_stall_i,
   output logic [31:0]         gnt_cnt0_o,
   output logic [31:0]         gnt_cnt1_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;

   state_e      state_q, state_d;
   logic        last_gnt_q, last_gnt_d;
   logic [31:0] gnt_cnt0_q, gnt_cnt0_d;
   logic [31:0] gnt_cnt1_q, gnt_cnt1_d;
   logic        tie_win1;

`ifdef CACHE_ARB_RR_EN
   assign tie_win1 = ~last_gnt_q;
`else
   assign tie_win1 = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         gnt_cnt0_q <= '0;
         gnt_cnt1_q <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         gnt_cnt0_q <= gnt_cnt0_d;
         gnt_cnt1_q <= gnt_cnt1_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      gnt_cnt0_d = gnt_cnt0_q;
      gnt_cnt1_d = gnt_cnt1_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_d = tie_win1 ? GNT1 : GNT0;
            else if (m0_cyc_i)        state_d = GNT0;
            else if (m1_cyc_i)        state_d = GNT1;
         end
         // Owner keeps the bus until it drops cyc; then hand straight to a waiting master.
         GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
         GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == GNT0 && state_q != GNT0) begin
         gnt_cnt0_d = gnt_cnt0_q + 32'd1;
         last_gnt_d = 1'b0;
      end
      if (state_d == GNT1 && state_q != GNT1) begin
         gnt_cnt1_d = gnt_cnt1_q + 32'd1;
         last_gnt_d = 1'b1;
      end
   end

   always_comb begin
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      s_we_o     = 1'b0;
      s_adr_o    = '0;
      s_dat_o    = '0;
      s_sel_o    = '0;
      m0_ack_o   = 1'b0;
      m0_stall_o = 1'b1;
      m0_dat_o   = '0;
      m1_ack_o   = 1'b0;
      m1_stall_o = 1'b1;
      m1_dat_o   = '0;
      case (state_q)
         GNT0: begin
            s_cyc_o    = m0_cyc_i;
            s_stb_o    = m0_stb_i;
            s_we_o     = m0_we_i;
            s_adr_o    = m0_adr_i;
            s_dat_o    = m0_dat_i;
            s_sel_o    = m0_sel_i;
            m0_ack_o   = s_ack_i;
            m0_stall_o = s_stall_i;
            m0_dat_o   = s_dat_i;
         end
         GNT1: begin
            s_cyc_o    = m1_cyc_i;
            s_stb_o    = m1_stb_i;
            s_we_o     = m1_we_i;
            s_adr_o    = m1_adr_i;
            s_dat_o    = m1_dat_i;
            s_sel_o    = m1_sel_i;
            m1_ack_o   = s_ack_i;
            m1_stall_o = s_stall_i;
            m1_dat_o   = s_dat_i;
         end
         default: ;
      endcase
   end

   assign gnt_cnt0_o = gnt_cnt0_q;
   assign gnt_cnt1_o = gnt_cnt1_q;

endmodule

// File: tb/tb_cache_arb.sv
// Randomized scoreboard bench for cache_arb: bench-side slave model, two master drivers,
// transaction scoreboard, grant log and directed arbitration/reset scenarios.
module tb_cache_arb;

   typedef struct packed {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  sel;
   } txn_t;

   typedef struct packed {
      int m;
      int c;
   } glog_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  cyc = '0, stb = '0, we = '0;
   logic [31:0] adr [2];
   logic [31:0] dat [2];
   logic [3:0]  sel [2];
   logic [31:0] m0_dat, m1_dat;
   logic        m0_ack, m1_ack, m0_stall, m1_stall;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_dat_i = '0;
   logic        s_ack_i = 1'b0, s_stall_i = 1'b0;
   logic [31:0] gnt_cnt0_o, gnt_cnt1_o;
   wire  [1:0]  mack   = {m1_ack, m0_ack};
   wire  [1:0]  mstall = {m1_stall, m0_stall};

   int          n_checks = 0, n_err = 0;
   int          cyc_n = 0;
   txn_t        q0[$], q1[$], sreq[$];
   glog_t       glog[$];
   logic [31:0] cnt_exp [2];
   int          last_model = 1;
   int          drop_cyc [2];
   int          slat_fixed = 0;
   bit          inject_ack = 0;
   logic [1:0]  pcyc = '0;
   logic [31:0] pc0 = '0, pc1 = '0;

   cache_arb #(.AWIDTH(32), .DWIDTH(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
      .m0_dat_i(dat[0]), .m0_sel_i(sel[0]), .m0_dat_o(m0_dat), .m0_ack_o(m0_ack), .m0_stall_o(m0_stall),
      .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
      .m1_dat_i(dat[1]), .m1_sel_i(sel[1]), .m1_dat_o(m1_dat), .m1_ack_o(m1_ack), .m1_stall_o(m1_stall),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
      .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_stall_i(s_stall_i), .gnt_cnt0_o(gnt_cnt0_o), .gnt_cnt1_o(gnt_cnt1_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Slave read data is a fixed function of the address (0x100 -> 0x12345678).
   function automatic logic [31:0] rdata(input logic [31:0] a);
      return a ^ 32'h1234_5778;
   endfunction

   function automatic int tie_winner();
`ifdef CACHE_ARB_RR_EN
      return (last_model == 1) ? 0 : 1;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Slave model: one outstanding request, acks after a latency, stalls while busy.
   initial begin
      txn_t        r;
      logic [31:0] radr;
      bit          acc, busy;
      int          cnt;
      busy = 0; cnt = 0; radr = '0;
      forever begin
         @(negedge clk);
         acc = s_cyc_o && s_stb_o && !s_stall_i;
         if (acc) begin
            r = '{adr: s_adr_o, we: s_we_o, dat: s_dat_o, sel: s_sel_o};
            sreq.push_back(r);
            radr = s_adr_o;
         end
         @(posedge clk); #1;
         s_ack_i = 1'b0;
         s_dat_i = $urandom;
         if (acc) begin
            busy = 1;
            cnt = (slat_fixed > 0) ? slat_fixed : $urandom_range(1, 3);
         end
         if (busy) begin
            cnt--;
            if (cnt == 0) begin
               busy = 0;
               s_ack_i = 1'b1;
               s_dat_i = rdata(radr);
            end
         end
         if (inject_ack) begin
            s_ack_i = 1'b1;
            inject_ack = 0;
         end
         s_stall_i = busy ? 1'b1 : ($urandom_range(0, 3) == 0);
      end
   end

   // Scoreboard monitor plus idle/exclusivity checks, sampled on the falling edge.
   always @(negedge clk) begin
      txn_t e, r;
      if (rst_n) begin
         for (int n = 0; n < 2; n++) begin
            if (mack[n]) begin
               if ((n == 0 ? q0.size() : q1.size()) == 0) fail("unexpected_ack");
               else if (sreq.size() == 0) fail("ack_without_slave_req");
               else begin
                  e = (n == 0) ? q0.pop_front() : q1.pop_front();
                  r = sreq.pop_front();
                  chk("ack_rdata", 64'(n == 0 ? m0_dat : m1_dat), 64'(rdata(e.adr)));
                  chk("slave_adr", 64'(r.adr), 64'(e.adr));
                  chk("slave_we_sel_dat", 64'({r.we, r.sel, r.dat}), 64'({e.we, e.sel, e.dat}));
               end
            end
            if (!cyc[n] && !pcyc[n])
               chk("nongranted_outs", 64'({mstall[n], mack[n], (n == 0 ? m0_dat : m1_dat)}), 64'({1'b1, 1'b0, 32'h0}));
         end
         if (cyc == 2'b00 && pcyc == 2'b00)
            chk("idle_slave_outs", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o}), 64'h0);
         if (cyc == 2'b00 && pcyc == 2'b00)
            chk("idle_slave_dat", 64'(s_dat_o), 64'h0);
         chk("one_owner", 64'(mstall == 2'b00), 64'h0);
      end
      pcyc <= cyc;
   end

   // Grant log: a counter stepping by one marks a grant to that master in this cycle.
   always @(negedge clk) begin
      if (gnt_cnt0_o == pc0 + 32'd1) glog.push_back('{m: 0, c: cyc_n});
      if (gnt_cnt1_o == pc1 + 32'd1) glog.push_back('{m: 1, c: cyc_n});
      pc0 <= gnt_cnt0_o;
      pc1 <= gnt_cnt1_o;
   end

   task automatic master_txn(input int n, input int ntx, input int wemode,
                             input logic [31:0] fadr, input bit fixed);
      txn_t e;
      int   g;
      @(posedge clk); #1;
      cyc[n] = 1'b1;
      for (int i = 0; i < ntx; i++) begin
         e.adr = fixed ? fadr : $urandom;
         e.we  = (wemode == 2) ? 1'($urandom_range(0, 1)) : 1'(wemode);
         e.dat = $urandom;
         e.sel = 4'($urandom_range(0, 15));
         adr[n] = e.adr; we[n] = e.we; dat[n] = e.dat; sel[n] = e.sel; stb[n] = 1'b1;
         if (n == 0) q0.push_back(e); else q1.push_back(e);
         g = 0;
         do begin @(negedge clk); g++; end while (mstall[n] && g < 400);
         if (mstall[n]) fail("stall_timeout");
         @(posedge clk); #1;
         stb[n] = 1'b0;
         g = 0;
         do begin @(negedge clk); g++; end while (!mack[n] && g < 400);
         if (!mack[n]) fail("ack_timeout");
         @(posedge clk); #1;
      end
      cyc[n] = 1'b0;
      we[n]  = 1'($urandom_range(0, 1));
      adr[n] = $urandom;
      dat[n] = $urandom;
      sel[n] = 4'($urandom_range(1, 15));
      drop_cyc[n] = cyc_n;
      cnt_exp[n]  = cnt_exp[n] + 32'd1;
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      chk("rst_cnt0", 64'(gnt_cnt0_o), 64'h0);
      chk("rst_cnt1", 64'(gnt_cnt1_o), 64'h0);
      chk("rst_scyc_stb", 64'({s_cyc_o, s_stb_o}), 64'h0);
      chk("rst_mstall", 64'(mstall), 64'h3);
      cnt_exp[0] = '0; cnt_exp[1] = '0; last_model = 1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic tie_round(input int exp_w);
      int base;
      base = glog.size();
      @(posedge clk); #1;
      cyc = 2'b11;
      @(negedge clk); @(negedge clk); #1;
      chk("tie_ngrants", 64'(glog.size() - base), 64'h1);
      if (glog.size() > base) chk("tie_winner", 64'(glog[base].m), 64'(exp_w));
      cnt_exp[exp_w] = cnt_exp[exp_w] + 32'd1;
      last_model = exp_w;
      @(posedge clk); #1;
      cyc = 2'b00;
      repeat (3) @(posedge clk);
   endtask

   task automatic chk_counts(input string name);
      chk({name, "_cnt0"}, 64'(gnt_cnt0_o), 64'(cnt_exp[0]));
      chk({name, "_cnt1"}, 64'(gnt_cnt1_o), 64'(cnt_exp[1]));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n0, n1, c0, g;
      bit seen;
      for (int n = 0; n < 2; n++) begin
         adr[n] = $urandom; dat[n] = $urandom; sel[n] = 4'hF;
      end
      cnt_exp[0] = '0; cnt_exp[1] = '0;
      do_reset();

      // Single read of 0x100 with a two-cycle slave latency.
      slat_fixed = 2;
      fork
         master_txn(0, 1, 0, 32'h100, 1'b1);
         begin
            @(negedge clk); chk("grant_latency_early", 64'(s_cyc_o), 64'h0);
            @(negedge clk); chk("grant_latency_one", 64'(s_cyc_o), 64'h1);
         end
      join
      repeat (2) @(posedge clk);
      chk_counts("single_read");
      slat_fixed = 0;

      // Simultaneous requests from IDLE.
      do_reset();
      tie_round(tie_winner());
      tie_round(tie_winner());
      chk_counts("tie");

      // m1 holds the bus for four writes while m0 waits; handoff without an idle cycle.
      base = glog.size();
      fork
         master_txn(1, 4, 1, 32'h0, 1'b0);
         begin repeat (3) @(posedge clk); master_txn(0, 1, 2, 32'h0, 1'b0); end
      join
      n0 = 0; n1 = 0; c0 = -1;
      for (int i = base; i < glog.size(); i++) begin
         if (glog[i].m == 0) begin n0++; c0 = glog[i].c; end
         else n1++;
      end
      chk("handoff_g0", 64'(n0), 64'h1);
      chk("handoff_g1", 64'(n1), 64'h1);
      chk("handoff_cycle", 64'(c0), 64'(drop_cyc[1] + 1));
      chk_counts("handoff");

      // Stray slave ack in IDLE is dropped.
      repeat (3) @(negedge clk);
      inject_ack = 1;
      @(negedge clk); #1;
      chk("idle_ack_dropped", 64'({m1_ack, m0_ack}), 64'h0);

      // Randomized concurrent traffic.
      for (int it = 0; it < 40; it++) begin
         fork
            begin repeat ($urandom_range(0, 3)) @(posedge clk); master_txn(0, $urandom_range(1, 3), 2, 32'h0, 1'b0); end
            begin repeat ($urandom_range(0, 3)) @(posedge clk); master_txn(1, $urandom_range(1, 3), 2, 32'h0, 1'b0); end
         join
      end
      repeat (2) @(posedge clk);
      chk_counts("random");

      // Counter wrap.
      @(negedge clk);
      force dut.gnt_cnt1_q = 32'hFFFF_FFFF;
      #1 release dut.gnt_cnt1_q;
      cnt_exp[1] = 32'hFFFF_FFFF;
      master_txn(1, 1, 2, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      chk("cnt1_wrap", 64'(gnt_cnt1_o), 64'h0);

      // Reset pulse during a granted m0 write; the late slave ack must not reach m0.
      do_reset();
      slat_fixed = 3;
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = $urandom; dat[0] = $urandom;
      g = 0;
      do begin @(negedge clk); g++; end while (m0_stall && g < 50);
      if (m0_stall) fail("rst_write_stall");
      @(posedge clk); #1;
      stb[0] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_scyc_stb", 64'({s_cyc_o, s_stb_o}), 64'h0);
      chk("rst_mid_cnts", 64'({gnt_cnt0_o, gnt_cnt1_o}), 64'h0);
      cyc[0] = 1'b0;
      cnt_exp[0] = '0; cnt_exp[1] = '0; last_model = 1;
      @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
         @(negedge clk);
         if (s_ack_i) begin
            seen = 1;
            chk("late_ack_blocked", 64'(m0_ack), 64'h0);
         end
      end
      if (!seen) fail("late_ack_window");
      sreq.delete();
      slat_fixed = 0;
      repeat (2) @(posedge clk);
      chk_counts("after_rst");

      chk("q_empty", 64'({q0.size() == 0, q1.size() == 0}), 64'h3);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
